// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC generator and DEPTH-entry instruction prefetch queue (optional perf counters: FETCH_QUEUE_PERF_EN)
module fetch_queue #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned INC      = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_incpc,
  input  logic              dec_ready,
  output logic              err
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              outstanding_q, outstanding_d;
  logic              discard_q, discard_d;
  logic              err_q, err_d;
  logic              started_q;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [ADDR_W-1:0] incpc_q [DEPTH];

  logic [CNT_W-1:0]  count;
  logic [ADDR_W:0]   pc_inc;
  logic              accept;
  logic              rsp_take;
  logic              push;
  logic              pop;

  // count includes the slot reserved by an outstanding request, so pushes never overflow
  assign count    = occ_q + CNT_W'(outstanding_q);
  assign pc_inc   = {1'b0, fetch_pc_q} + (ADDR_W + 1)'(INC);

  // started_q holds requests off until the first edge after reset release
  assign imem_req_valid = started_q & ~halt & ~outstanding_q & ~redirect_valid
                        & (count < CNT_W'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  assign accept   = imem_req_valid & imem_req_ready;
  assign rsp_take = imem_rsp_valid & outstanding_q;
  assign push     = rsp_take & ~discard_q & ~redirect_valid;
  assign pop      = inst_valid & dec_ready & ~redirect_valid;

  assign inst_valid = (occ_q != '0);
  assign inst       = data_q[rd_ptr_q];
  assign inst_pc    = pc_q[rd_ptr_q];
  assign inst_incpc = incpc_q[rd_ptr_q];
  assign err        = err_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    pend_pc_d     = pend_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    err_d         = err_q;
    occ_d         = occ_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      occ_d      = '0;
      rd_ptr_d   = wr_ptr_q;
      // a response still in flight keeps its slot reserved but is marked for discard
      if (outstanding_q && !imem_rsp_valid) begin
        discard_d = 1'b1;
      end else begin
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end
      if (redirect_pc[0]) begin
        err_d = 1'b1;
      end
    end else begin
      if (accept) begin
        outstanding_d = 1'b1;
        pend_pc_d     = fetch_pc_q;
        fetch_pc_d    = pc_inc[ADDR_W-1:0];
        if (pc_inc[ADDR_W]) begin
          err_d = 1'b1;
        end
      end
      if (rsp_take) begin
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + CNT_W'(1);
        2'b01:   occ_d = occ_q - CNT_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= ADDR_W'(RESET_PC);
      pend_pc_q     <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      err_q         <= 1'b0;
      started_q     <= 1'b0;
      occ_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      pend_pc_q     <= pend_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      err_q         <= err_d;
      started_q     <= 1'b1;
      occ_q         <= occ_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        pc_q[i]    <= '0;
        incpc_q[i] <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q]  <= imem_rsp_data;
      pc_q[wr_ptr_q]    <= pend_pc_q;
      incpc_q[wr_ptr_q] <= pend_pc_q + ADDR_W'(INC);
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!inst_valid && !halt && stall_q != '1) begin
        stall_q <= stall_q + 32'd1;
      end
      if (redirect_valid && (inst_valid || outstanding_q) && flush_q != '1) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req_valid;
  logic [15:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [15:0] inst_incpc;
  logic        dec_ready;
  logic        err;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  int          tests = 0;
  int          fails = 0;
  int          mem_lat;
  int          mem_wait;
  logic [15:0] mem_addr;
  int          acc_cnt;
  int          acc_snap;

  fetch_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_incpc     (inst_incpc),
    .dec_ready      (dec_ready),
    .err            (err)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock: sample an accept mid-cycle, then model the memory response latency
  task automatic cycle();
    logic acc;
    #1;
    acc = imem_req_valid && imem_req_ready;
    if (acc) begin
      mem_addr = imem_req_addr;
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (acc) mem_wait = mem_lat;
    if (mem_wait > 0) begin
      mem_wait--;
      if (mem_wait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_addr ^ 16'hA5A5;
      end
    end
    #1;
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 16'h0000;
    mem_wait       = 0;
    mem_lat        = 1;
    acc_cnt        = 0;
    #1;
  endtask

  initial begin
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    apply_reset();
    #1;
    check("rst_inst_valid", inst_valid, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_err", err, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_inst_incpc", inst_incpc, 0);
    repeat (2) @(posedge clk);
    reset_release();

    // sequential stream with a 1-cycle memory
    cycle();
    check("t1_req_valid", imem_req_valid, 1);
    check("t1_req_addr0", imem_req_addr, 16'h0000);
    cycle();
    check("t1_busy", imem_req_valid, 0);
    check("t1_no_fallthru", inst_valid, 0);
    cycle();
    check("t1_first_valid", inst_valid, 1);
    check("t1_pc0", inst_pc, 16'h0000);
    check("t1_inc0", inst_incpc, 16'h0002);
    check("t1_inst0", inst, 16'hA5A5);
    check("t1_req_addr2", imem_req_addr, 16'h0002);
    cycle();
    cycle();
    check("t1_pc2", inst_pc, 16'h0002);
    check("t1_inc2", inst_incpc, 16'h0004);
    check("t1_req_addr4", imem_req_addr, 16'h0004);
    cycle();
    cycle();
    check("t1_pc4", inst_pc, 16'h0004);
    check("t1_inc4", inst_incpc, 16'h0006);
    check("t1_inst4", inst, 16'hA5A1);

    // asynchronous reset while a request is being presented
    check("t1_pre_rst_req", imem_req_valid, 1);
    apply_reset();
    check("arst_req_valid", imem_req_valid, 0);
    check("arst_inst_valid", inst_valid, 0);
    check("arst_inst_pc", inst_pc, 0);
    check("arst_inst", inst, 0);
    dec_ready = 1'b0;
    reset_release();

    // fill with decode stalled
    repeat (10) cycle();
    check("t2_acc_cnt", acc_cnt, 4);
    check("t2_full_req", imem_req_valid, 0);
    check("t2_head_pc", inst_pc, 16'h0000);
    dec_ready = 1'b1;
    cycle();
    dec_ready = 1'b0;
    #1;
    check("t2_req_after_pop", imem_req_valid, 1);
    check("t2_req_addr8", imem_req_addr, 16'h0008);
    check("t2_head_pc2", inst_pc, 16'h0002);

    // redirect with a slow request outstanding and two entries queued
    apply_reset();
    dec_ready = 1'b0;
    reset_release();
    repeat (7) cycle();
    check("t3_req_addr6", imem_req_addr, 16'h0006);
    dec_ready = 1'b1;
    mem_lat   = 3;
    cycle();
    dec_ready = 1'b0;
    #1;
    check("t3_head_pc2", inst_pc, 16'h0002);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("t3_flushed", inst_valid, 0);
    check("t3_wait_rsp", imem_req_valid, 0);
    cycle();
    check("t3_stale_rsp", imem_rsp_valid, 1);
    cycle();
    check("t3_dropped", inst_valid, 0);
    check("t3_req_valid", imem_req_valid, 1);
    check("t3_req_addr", imem_req_addr, 16'h0100);
    mem_lat   = 1;
    dec_ready = 1'b1;
    cycle();
    cycle();
    check("t3_new_valid", inst_valid, 1);
    check("t3_new_pc", inst_pc, 16'h0100);
    check("t3_new_inst", inst, 16'hA4A5);
    check("t3_new_inc", inst_incpc, 16'h0102);

    // redirect in the same cycle as the response
    cycle();
    check("t4_rsp_now", imem_rsp_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0200;
    #1;
    check("t4_no_req_redirect", imem_req_valid, 0);
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("t4_dropped", inst_valid, 0);
    check("t4_req_valid", imem_req_valid, 1);
    check("t4_req_addr", imem_req_addr, 16'h0200);
    cycle();
    cycle();
    check("t4_pc", inst_pc, 16'h0200);
    check("t4_inst", inst, 16'hA7A5);

    // halt drains the queue and blocks requests
    halt = 1'b1;
    #1;
    check("t5_halt_req", imem_req_valid, 0);
    acc_snap = acc_cnt;
    cycle();
    check("t5_drained", inst_valid, 0);
    cycle();
    check("t5_still_halted", imem_req_valid, 0);
    check("t5_no_accepts", acc_cnt, acc_snap);
    halt = 1'b0;
    #1;
    check("t5_resume_valid", imem_req_valid, 1);
    check("t5_resume_addr", imem_req_addr, 16'h0202);

    // misaligned redirect sets sticky error
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0101;
    #1;
    check("t6_redirect_gates_req", imem_req_valid, 0);
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("t6_err_set", err, 1);
    check("t6_req_addr", imem_req_addr, 16'h0101);
    cycle();
    cycle();
    check("t6_err_sticky", err, 1);
    check("t6_fetch_continues", inst_pc, 16'h0101);

    apply_reset();
    check("t7_err_cleared", err, 0);
    check("t7_req_cleared", imem_req_valid, 0);
    reset_release();

    // PC wrap past 2^ADDR_W
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("t8_err_before", err, 0);
    check("t8_req_addr", imem_req_addr, 16'hFFFE);
    cycle();
    check("t8_err_wrap", err, 1);
    cycle();
    check("t8_head_pc", inst_pc, 16'hFFFE);
    check("t8_head_incpc", inst_incpc, 16'h0000);
    check("t8_req_wrapped", imem_req_addr, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
